mmio_controller: RTL and testbench
==================================

MMIO_CONTROLLER -- requirements
Module: mmio_controller

Interface
REQ-001 SHALL have parameters FIFO_DEPTH (default 8; power of two, 2..16): depth of the keyboard FIFO.
REQ-002 SHALL have parameter ADDR_SW (default 4096): switch read address.
REQ-003 SHALL have parameter ADDR_LED (default 4097): LED write/read address.
REQ-004 SHALL have parameter ADDR_KEY (default 4098): keyboard data pop address.
REQ-005 SHALL have parameter ADDR_KSTAT (default 4099): keyboard status address.
REQ-006 SHALL have parameter ADDR_TIMER (default 4100): cycle timer address.
REQ-007 SHALL have ports:
  clock  in  1  system clock; all state changes on its rising edge.
  reset  in  1  asynchronous, active-high.
  addr  in  32  processor data address (address_dmem).
  wdata  in  32  processor store data.
  wren  in  1  processor store enable.
  rden  in  1  one-cycle load strobe from the processor memory stage.
  ram_q  in  32  RAM read data.
  ram_wren  out  1  gated write enable to RAM.
  q_dmem  out  32  load data returned to processor.
  sw  in  16  raw board switches, asynchronous.
  led  out  16  board LEDs.
  key_valid  in  1  PS/2 receiver has a scan code.
  key_data  in  8  PS/2 scan code.
  key_ready  out  1  controller accepts scan code this cycle.

Function
REQ-008 io_hit SHALL be true when addr equals any of the five I/O addresses (full 32-bit compare); all other addresses are RAM.
REQ-009 ram_wren SHALL equal wren AND NOT io_hit (combinational).
REQ-010 q_dmem SHALL be combinational: ram_q when not io_hit; otherwise the selected I/O register zero-extended to 32 bits.
REQ-011 sw SHALL pass through a two-flop synchronizer; a read of ADDR_SW returns the second flop, so a switch change is visible 2 cycles after it settles.
REQ-012 A cycle with wren=1 and addr=ADDR_LED SHALL load wdata[15:0] into led on that edge; reads of ADDR_LED return led; led otherwise holds.
REQ-013 The keyboard FIFO SHALL push key_data on an edge where key_valid and key_ready are both 1.
REQ-014 key_ready SHALL equal NOT full; when full, a push is refused even if a pop occurs in the same cycle.
REQ-015 A read of ADDR_KEY SHALL return {23'b0, 1, head[7:0]} when non-empty and 0 when empty.
REQ-016 An edge with rden=1 and addr=ADDR_KEY SHALL pop the head entry when non-empty; a pop on empty is ignored with no pointer or count change.
REQ-017 Simultaneous push and pop when non-empty and not full SHALL leave count unchanged and preserve order.
REQ-018 Read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-019 A read of ADDR_KSTAT SHALL return {count in bits [4:0], full in bit 5, empty in bit 6}, upper bits 0.
REQ-020 A store to ADDR_KEY or ADDR_KSTAT SHALL be ignored; a store to ADDR_SW SHALL be ignored.

Reset
REQ-021 While reset=1, the block SHALL force led=0, the synchronizer flops to 0, FIFO pointers and count to 0, and the timer to 0, independent of clock.
REQ-022 While reset=1, key_ready SHALL be 1 and ram_wren SHALL still follow REQ-009.
REQ-023 Reset asserted mid-operation SHALL discard FIFO contents; the first edge after release SHALL behave as post-reset.

Configuration
REQ-024 With macro MMIO_TIMER_EN defined, a 32-bit counter SHALL increment by 1 every cycle, wrap from 0xFFFFFFFF to 0, and be read at ADDR_TIMER.
REQ-025 With MMIO_TIMER_EN defined, a store to ADDR_TIMER SHALL load wdata, and counting SHALL resume from that value on the next edge.
REQ-026 Without MMIO_TIMER_EN, no counter SHALL be built; ADDR_TIMER reads return 0, stores to it are ignored, and the address still counts as io_hit.

Verification
REQ-027 Store 0x0000ABCD to 4097 -> led=0xABCD next edge; ram_wren=0 that cycle; read 4097 -> 0x0000ABCD.
REQ-028 sw=0x00F0 at cycle N, read 4096 -> 0x000000F0 from cycle N+2 onward, not before.
REQ-029 Push 0x1C,0x32 then pop twice -> reads 0x11C, 0x132, then 0x0; status count 2->1->0; empty bit set at end.
REQ-030 Push FIFO_DEPTH codes -> key_ready=0 and status=0x28 (depth 8); push+pop same cycle -> push refused, count 7.
REQ-031 Store to address 12 -> ram_wren=1; load address 12 -> q_dmem=ram_q.
REQ-032 With MMIO_TIMER_EN, store 0xFFFFFFFE to 4100 -> reads 0xFFFFFFFF then 0; assert reset mid-count -> 0; without macro -> reads 0.

Source files
------------

// File: rtl/mmio_controller.sv
// Memory-mapped I/O front end: decodes switch, LED, keyboard FIFO and timer registers and gates RAM writes.
// Optional cycle timer is built only when MMIO_TIMER_EN is defined; otherwise its address reads as zero.
module mmio_controller #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] ADDR_SW    = 32'd4096,
    parameter logic [31:0] ADDR_LED   = 32'd4097,
    parameter logic [31:0] ADDR_KEY   = 32'd4098,
    parameter logic [31:0] ADDR_KSTAT = 32'd4099,
    parameter logic [31:0] ADDR_TIMER = 32'd4100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wren,
    input  logic        rden,
    input  logic [31:0] ram_q,
    output logic        ram_wren,
    output logic [31:0] q_dmem,
    input  logic [15:0] sw,
    output logic [15:0] led,
    input  logic        key_valid,
    input  logic [7:0]  key_data,
    output logic        key_ready
);
    localparam int         PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

    logic [15:0]      sw_meta_q, sw_sync_q;
    logic [15:0]      led_q, led_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]       count_q, count_d;
    logic [31:0]      timer_val;
    logic [31:0]      io_data;

    logic hit_sw, hit_led, hit_key, hit_kstat, hit_timer, io_hit;
    logic full, empty, push, pop;

    assign hit_sw    = (addr == ADDR_SW);
    assign hit_led   = (addr == ADDR_LED);
    assign hit_key   = (addr == ADDR_KEY);
    assign hit_kstat = (addr == ADDR_KSTAT);
    assign hit_timer = (addr == ADDR_TIMER);
    assign io_hit    = hit_sw | hit_led | hit_key | hit_kstat | hit_timer;

    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == 5'd0);
    // A full FIFO refuses the push even if a pop frees a slot this cycle.
    assign push      = key_valid & ~full;
    assign pop       = rden & hit_key & ~empty;

    assign ram_wren  = wren & ~io_hit;
    assign key_ready = ~full;
    assign led       = led_q;

    always_comb begin
        led_d    = led_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wren && hit_led) led_d = wdata[15:0];
        if (push) begin
            mem_d[wr_ptr_q] = key_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            led_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
            led_q     <= led_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

`ifdef MMIO_TIMER_EN
    logic [31:0] timer_q, timer_d;

    always_comb begin
        timer_d = timer_q + 32'd1;
        if (wren && hit_timer) timer_d = wdata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) timer_q <= '0;
        else       timer_q <= timer_d;
    end

    assign timer_val = timer_q;
`else
    assign timer_val = 32'd0;
`endif

    always_comb begin
        io_data = 32'd0;
        if (hit_sw)         io_data = {16'd0, sw_sync_q};
        else if (hit_led)   io_data = {16'd0, led_q};
        else if (hit_key)   io_data = empty ? 32'd0 : {23'd0, 1'b1, mem_q[rd_ptr_q]};
        else if (hit_kstat) io_data = {25'd0, empty, full, count_q};
        else if (hit_timer) io_data = timer_val;
        q_dmem = io_hit ? io_data : ram_q;
    end
endmodule

// File: tb/tb_mmio_controller.sv
// Directed bench for mmio_controller: the driver queues expected outputs, a negedge monitor compares them.
module tb_mmio_controller;
    localparam logic [31:0] A_SW    = 32'd4096;
    localparam logic [31:0] A_LED   = 32'd4097;
    localparam logic [31:0] A_KEY   = 32'd4098;
    localparam logic [31:0] A_KSTAT = 32'd4099;
    localparam logic [31:0] A_TIMER = 32'd4100;

    localparam int SEL_Q     = 0;
    localparam int SEL_RAMWE = 1;
    localparam int SEL_KRDY  = 2;
    localparam int SEL_LED   = 3;

    logic        clock, reset;
    logic [31:0] addr, wdata, ram_q, q_dmem;
    logic        wren, rden, ram_wren;
    logic [15:0] sw, led;
    logic        key_valid, key_ready;
    logic [7:0]  key_data;

    logic [31:0] exp_q[$];
    int          sel_q[$];
    string       name_q[$];
    int          tests_run = 0;
    int          tests_failed = 0;

    mmio_controller dut (
        .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .wren(wren),
        .rden(rden), .ram_q(ram_q), .ram_wren(ram_wren), .q_dmem(q_dmem),
        .sw(sw), .led(led), .key_valid(key_valid), .key_data(key_data),
        .key_ready(key_ready)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Driver tasks: inputs change 1 time unit after the rising edge
    task automatic step();
        @(posedge clock);
        #1;
        wren      = 1'b0;
        rden      = 1'b0;
        key_valid = 1'b0;
    endtask

    task automatic expect_out(input int sel, input logic [31:0] val, input string nm);
        exp_q.push_back(val);
        sel_q.push_back(sel);
        name_q.push_back(nm);
    endtask

    task automatic push_key(input logic [7:0] code);
        key_valid = 1'b1;
        key_data  = code;
    endtask

    // Scoreboard monitor: everything queued during a cycle is checked at its falling edge
    always @(negedge clock) begin
        while (exp_q.size() > 0) begin
            logic [31:0] e, a;
            int          s;
            string       n;
            e = exp_q.pop_front();
            s = sel_q.pop_front();
            n = name_q.pop_front();
            case (s)
                SEL_Q:     a = q_dmem;
                SEL_RAMWE: a = {31'd0, ram_wren};
                SEL_KRDY:  a = {31'd0, key_ready};
                default:   a = {16'd0, led};
            endcase
            tests_run++;
            if (a !== e) begin
                tests_failed++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", n, a, e);
            end
        end
    end

    initial begin
        reset = 1'b1; addr = '0; wdata = '0; wren = 1'b0; rden = 1'b0;
        ram_q = 32'h0; sw = 16'h0; key_valid = 1'b0; key_data = 8'h0;

        // Behaviour while reset is held
        step(); addr = A_LED; wren = 1'b1; wdata = 32'h1234;
        expect_out(SEL_RAMWE, 32'd0, "rst_ram_wren_io");
        expect_out(SEL_Q, 32'd0, "rst_led_read");
        expect_out(SEL_KRDY, 32'd1, "rst_key_ready");
        step(); addr = 32'd12; wren = 1'b1;
        expect_out(SEL_RAMWE, 32'd1, "rst_ram_wren_ram");
        expect_out(SEL_LED, 32'd0, "rst_led_held");
        step(); reset = 1'b0;

        // LED store and readback
        step(); addr = A_LED; wren = 1'b1; wdata = 32'h0000ABCD;
        expect_out(SEL_RAMWE, 32'd0, "led_store_ram_wren");
        step(); addr = A_LED;
        expect_out(SEL_Q, 32'h0000ABCD, "led_read");
        expect_out(SEL_LED, 32'h0000ABCD, "led_port");

        // RAM pass-through
        step(); addr = 32'd12; wren = 1'b1; ram_q = 32'hDEADBEEF;
        expect_out(SEL_RAMWE, 32'd1, "ram_store_wren");
        expect_out(SEL_Q, 32'hDEADBEEF, "ram_load_data");

        // Switch synchronizer latency
        step(); sw = 16'h00F0; addr = A_SW;
        expect_out(SEL_Q, 32'd0, "sw_cycle_n");
        step(); addr = A_SW;
        expect_out(SEL_Q, 32'd0, "sw_cycle_n1");
        step(); addr = A_SW;
        expect_out(SEL_Q, 32'h000000F0, "sw_cycle_n2");
        step(); addr = A_SW; wren = 1'b1; wdata = 32'hFFFF;
        expect_out(SEL_RAMWE, 32'd0, "sw_store_ram_wren");
        step(); addr = A_LED;
        expect_out(SEL_Q, 32'h0000ABCD, "led_holds");
        step(); addr = A_SW;
        expect_out(SEL_Q, 32'h000000F0, "sw_store_ignored");

        // Two pushes then two pops
        step(); push_key(8'h1C); addr = A_KSTAT;
        expect_out(SEL_Q, 32'h40, "kstat_empty");
        expect_out(SEL_KRDY, 32'd1, "key_ready_empty");
        step(); push_key(8'h32); addr = A_KSTAT;
        expect_out(SEL_Q, 32'h01, "kstat_one");
        step(); addr = A_KSTAT;
        expect_out(SEL_Q, 32'h02, "kstat_two");
        step(); addr = A_KEY; rden = 1'b1;
        expect_out(SEL_Q, 32'h11C, "key_pop1");
        step(); addr = A_KSTAT;
        expect_out(SEL_Q, 32'h01, "kstat_after_pop1");
        step(); addr = A_KEY; rden = 1'b1;
        expect_out(SEL_Q, 32'h132, "key_pop2");
        step(); addr = A_KSTAT;
        expect_out(SEL_Q, 32'h40, "kstat_after_pop2");
        step(); addr = A_KEY; rden = 1'b1;
        expect_out(SEL_Q, 32'h0, "key_read_empty");
        step(); addr = A_KSTAT;
        expect_out(SEL_Q, 32'h40, "kstat_pop_empty_ignored");

        // Fill to full (pointers wrap), refused push during pop, drain in order
        for (int i = 0; i < 8; i++) begin
            step(); push_key(8'h10 + 8'(i)); addr = A_SW;
        end
        step(); addr = A_KSTAT;
        expect_out(SEL_Q, 32'h28, "kstat_full");
        expect_out(SEL_KRDY, 32'd0, "key_ready_full");
        step(); push_key(8'hEE); addr = A_KEY; rden = 1'b1;
        expect_out(SEL_Q, 32'h110, "full_pop_head");
        expect_out(SEL_KRDY, 32'd0, "key_ready_full_pop");
        step(); addr = A_KSTAT;
        expect_out(SEL_Q, 32'h07, "kstat_push_refused");
        expect_out(SEL_KRDY, 32'd1, "key_ready_after_pop");
        for (int i = 1; i < 8; i++) begin
            step(); addr = A_KEY; rden = 1'b1;
            expect_out(SEL_Q, 32'h110 + 32'(i), $sformatf("drain_%0d", i));
        end
        step(); addr = A_KSTAT;
        expect_out(SEL_Q, 32'h40, "kstat_drained");

        // Simultaneous push and pop, stores to keyboard registers
        step(); push_key(8'h5A); addr = A_KSTAT;
        step(); push_key(8'h6B); addr = A_KEY; rden = 1'b1;
        expect_out(SEL_Q, 32'h15A, "pushpop_head");
        step(); addr = A_KSTAT;
        expect_out(SEL_Q, 32'h01, "pushpop_count");
        step(); addr = A_KEY; wren = 1'b1; wdata = 32'hFF;
        expect_out(SEL_RAMWE, 32'd0, "key_store_ram_wren");
        expect_out(SEL_Q, 32'h16B, "pushpop_order");
        step(); addr = A_KSTAT; wren = 1'b1; wdata = 32'h0;
        expect_out(SEL_Q, 32'h01, "key_store_ignored");

        // Timer address
`ifdef MMIO_TIMER_EN
        step(); addr = A_TIMER; wren = 1'b1; wdata = 32'hFFFFFFFE;
        expect_out(SEL_RAMWE, 32'd0, "timer_store_ram_wren");
        step(); addr = A_TIMER;
        expect_out(SEL_Q, 32'hFFFFFFFE, "timer_loaded");
        step(); addr = A_TIMER;
        expect_out(SEL_Q, 32'hFFFFFFFF, "timer_max");
        step(); addr = A_TIMER;
        expect_out(SEL_Q, 32'h0, "timer_wrap");
        step(); addr = A_TIMER;
        expect_out(SEL_Q, 32'h1, "timer_after_wrap");
`else
        step(); addr = A_TIMER; wren = 1'b1; wdata = 32'h55;
        expect_out(SEL_RAMWE, 32'd0, "timer_store_ram_wren");
        expect_out(SEL_Q, 32'h0, "timer_absent_read");
        step(); addr = A_TIMER;
        expect_out(SEL_Q, 32'h0, "timer_store_ignored");
`endif

        // Reset mid-operation with one entry still queued
        step(); reset = 1'b1; addr = A_TIMER;
        expect_out(SEL_Q, 32'h0, "rst_mid_timer");
        step(); addr = A_KSTAT;
        expect_out(SEL_Q, 32'h40, "rst_mid_fifo");
        expect_out(SEL_KRDY, 32'd1, "rst_mid_key_ready");
        step(); reset = 1'b0; addr = A_TIMER;
        expect_out(SEL_Q, 32'h0, "post_rst_timer");
        step(); addr = A_LED;
        expect_out(SEL_Q, 32'h0, "post_rst_led");
        step(); addr = A_KEY; rden = 1'b1;
        expect_out(SEL_Q, 32'h0, "post_rst_key_empty");

        step();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        if (exp_q.size() > 0) begin
            tests_failed++;
            $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
